// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Imported by the serial_adder top.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Existing single-bit combinational full adder cell.
// One evaluation per clock when driven by serial_adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic S
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder around one full_adder cell.
// The carry register closes the loop between cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .A   (sa[0]),
    .B   (sb[0]),
    .Cin (carry),
    .Cout(fa_co),
    .S   (fa_s)
  );

  assign acc_nxt = {fa_s, acc[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          acc   <= acc_nxt;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          // outputs only move on the last bit
          if (last) begin
            sum   <= acc_nxt;
            cout  <= fa_co;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=4).
// Reference model is plain integer addition.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8;

  logic       rst4, start4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4;

  int tests = 0;
  int fails = 0;
  logic [8:0] last8 = '0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst  (rst8),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk  (clk),
    .rst  (rst4),
    .start(start4),
    .a    (a4),
    .b    (b4),
    .cin  (cin4),
    .busy (busy4),
    .done (done4),
    .sum  (sum4),
    .cout (cout4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x,
                                      input logic [7:0] y,
                                      input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic c);
    return 5'(x) + 5'(y) + 5'(c);
  endfunction

  // lat counts cycles after the accepting edge, that cycle being 1
  task automatic wait8(output int lat, input int lat0,
                       input bit scr, input logic [8:0] hold);
    lat = lat0;
    while (!done8 && lat < 40) begin
      chk("busy8", busy8, 1'b1);
      chk("hold8", {cout8, sum8}, hold);
      if (scr) begin
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("done8_seen", done8, 1'b1);
    chk("excl8", busy8, 1'b0);
  endtask

  task automatic launch8(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc);
    logic [8:0] exp;
    int lat;
    exp = ref8(ta, tb, tc);
    launch8(ta, tb, tc);
    wait8(lat, 1, 1'b1, last8);
    chk("lat8", lat, 9);
    chk("res8", {cout8, sum8}, exp);
    last8 = exp;
    @(posedge clk); #1;
    chk("pulse8", done8, 1'b0);
    chk("keep8", {cout8, sum8}, exp);
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb,
                     input logic tc);
    int lat;
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("lat4", lat, 5);
    chk("res4", {cout4, sum4}, ref4(ta, tb, tc));
    @(posedge clk); #1;
    chk("pulse4", done4, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst4 = 1'b0;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_res", {cout8, sum8}, 9'h000);
    chk("rst_busy4", busy4, 1'b0);

    op8(8'h3C, 8'h42, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1);
    op8(8'h00, 8'h00, 1'b1);

    // start during RUN is ignored
    launch8(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(lat, 4, 1'b0, last8);
    chk("ign_lat", lat, 9);
    chk("ign_res", {cout8, sum8}, 9'h030);
    last8 = 9'h030;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    chk("ign_pulses", pulses, 0);

    // back-to-back accept from DONE
    launch8(8'h3C, 8'h42, 1'b0);
    wait8(lat, 1, 1'b0, last8);
    chk("b2b_res1", {cout8, sum8}, 9'h07E);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(lat, 1, 1'b1, 9'h07E);
    chk("b2b_lat", lat, 9);
    chk("b2b_res2", {cout8, sum8}, 9'h100);
    last8 = 9'h100;
    @(posedge clk); #1;
    chk("b2b_pulse", done8, 1'b0);

    // reset in the middle of a run
    launch8(8'h55, 8'h55, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    last8 = '0;
    chk("mid_busy", busy8, 1'b0);
    chk("mid_done", done8, 1'b0);
    chk("mid_res", {cout8, sum8}, 9'h000);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) pulses++;
    end
    chk("mid_quiet", pulses, 0);
    op8(8'h01, 8'h02, 1'b0);

    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++)
          op4(4'(i), 4'(j), 1'(c));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder built around the team's existing combinational full_adder cell. It accepts two WIDTH-bit operands and a carry-in, then adds them LSB-first with one full_adder evaluation per clock. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly upstream of the full_adder: it sequences operand bits into the cell and consumes the cell's S/Cout each cycle.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled on rising clk
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in, captured when start is accepted
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  one-cycle pulse; sum/cout are valid
sum  output  WIDTH  result bits; held stable from done until the next accepted start
cout  output  1  final carry-out; held with sum

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry and bit counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, capture a and b into shift regs sa and sb, capture cin into carry, set cnt=0, go to RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - full_adder inputs are sa[0], sb[0], carry.
  - sa and sb shift right by 1 (MSB fill 0).
  - Sum shift register shifts right with S entering at bit WIDTH-1.
  - carry <= Cout.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 on this edge, go to DONE.
- DONE: done=1 for exactly this one cycle. cout reflects the final carry. Next state is RUN if start=1 (back-to-back accept with the same capture as IDLE), otherwise IDLE.
- Latency: start accepted on edge k. RUN occupies cycles after edges k+1..k+WIDTH. done is high in the cycle following edge k+WIDTH, so done appears WIDTH+1 cycles after start is sampled.
- busy equals (state==RUN). busy and done are never high together.
- start while in RUN is ignored: no restart, operands unchanged.
- sum and cout outputs update only on the transition into DONE. They hold the previous result throughout RUN, so intermediate shifting is not visible on the outputs.
- Width rules:
  - cnt is $clog2(WIDTH)+1 bits.
  - Arithmetic is unsigned; result equals {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - No overflow flag.
- rst asserted mid-operation (any state) overrides everything on that edge: return to reset values, discard the addition in progress, no done pulse.
- rst and start high on the same edge: rst wins, start is lost.
- a, b and cin changing during RUN have no effect.

Decomposition:
- Shared package serial_adder_pkg:
  - state typedef enum {IDLE, RUN, DONE} (2 bits)
  - constant SA_DEFAULT_WIDTH = 8
- One sub-module instance: full_adder (existing cell, ports A, B, Cin, Cout, S), purely combinational. There is no second instance; the carry register closes the loop.

Test Plan:
1. WIDTH=8: rst high 2 cycles, then low -> busy=0, done=0, sum=0x00, cout=0. Pulse start with a=0x3C, b=0x42, cin=0 -> done pulses exactly 9 cycles after start is sampled, sum=0x7E, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. Start a=0x10, b=0x20; assert start again at RUN cycle 3 with a=0xFF, b=0xFF -> second start ignored, result sum=0x30, cout=0, single done pulse.
4. Back-to-back: hold start=1 in the DONE cycle with a=0x80, b=0x80, cin=0 -> first result delivered, second done 9 cycles later with sum=0x00, cout=1. First result holds on the outputs during the second RUN.
5. Reset mid-op: start a=0x55, b=0x55; assert rst for 1 cycle at RUN cycle 4 -> no done pulse, sum=0x00, cout=0, busy=0 the next cycle. A following start with a=0x01, b=0x02 yields sum=0x03.
6. WIDTH=4: exhaustive sweep of all a, b in 0..15 and cin in {0,1} (512 ops) -> {cout,sum} == a+b+cin for every op, each done exactly 5 cycles after start.
